param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter. It is the next generation of the 4-bit enable/clear up counter, generalised in width and modulus. It adds direction control, synchronous parallel load, a wrap/saturate mode, a cascadable terminal-count output and a sticky overflow flag. It serves as the general counting primitive for timers, decade counters and display scanners in the lab designs.

Parameters:
WIDTH, 4, bit width of the count register Q.
MAX_VAL, 2**WIDTH-1, highest count value; the count range is 0..MAX_VAL (modulus MAX_VAL+1). Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
RESET_VAL, 0, value loaded into Q by CLR. Must satisfy 0 <= RESET_VAL <= MAX_VAL.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
CLR  input  1  asynchronous, active-high reset.
E  input  1  count enable.
UP  input  1  direction: 1 = count up, 0 = count down.
LD  input  1  synchronous parallel load.
D  input  WIDTH  load data.
SAT  input  1  boundary mode: 1 = saturate, 0 = wrap.
OVF_CLR  input  1  synchronous clear of the OVF flag.
Q  output  WIDTH  current count (registered).
TC  output  1  terminal count (combinational, for cascading).
OVF  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Clock/reset: one clock, CLK. CLR is asynchronous, active-high. While CLR=1: Q=RESET_VAL and OVF=0 immediately, with no clock edge needed. TC follows the formula below using Q=RESET_VAL.
- Update priority on each rising CLK edge: CLR > LD > E. When none of these applies, Q holds.
- Load (LD=1):
  - Q <= D if D <= MAX_VAL; otherwise Q <= MAX_VAL (clamp).
  - Load takes effect regardless of E, UP or SAT.
  - A load never sets OVF.
- Count (LD=0, E=1):
  - UP=1 and Q<MAX_VAL: Q <= Q+1.
  - UP=0 and Q>0: Q <= Q-1.
  - Boundary (UP=1 and Q==MAX_VAL, or UP=0 and Q==0):
    - SAT=0 (wrap): up wraps to 0; down wraps to MAX_VAL.
    - SAT=1 (saturate): Q holds.
    - In both modes OVF is set on the same edge.
- E=0 with LD=0: Q holds, OVF is unaffected (apart from OVF_CLR).
- TC = E & ~LD & ((UP & Q==MAX_VAL) | (~UP & Q==0)).
  - Purely combinational, no latency.
  - Asserted exactly in the cycle where the next edge would cross the boundary.
  - TC of stage n drives E of stage n+1 in cascades.
- OVF:
  - Set on any boundary-crossing count (the TC=1 edge).
  - Cleared by OVF_CLR=1 on an edge.
  - Set has priority over OVF_CLR if both occur on the same edge.
  - CLR clears it asynchronously.
- Latency: Q changes one edge after LD or E is sampled. OVF changes on the same edge as the boundary wrap.
- Arithmetic:
  - Width-safe; no intermediate overflow of WIDTH bits.
  - MAX_VAL=2**WIDTH-1 must give identical results to a natural binary wrap.
- Mid-operation reset: CLR asserted between edges forces Q and OVF at once. On CLR release, the first edge with E=1 counts from RESET_VAL.
- Direction change takes effect on the next edge with no dead cycle.
- X-free outputs required after the first CLR.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SAT=0, UP=1, E=1 from CLR release -> Q sequence 0,1,...,9,0. TC=1 only while Q=9. OVF=1 after the 9->0 edge.
2. Same config, UP=0 from Q=0 -> Q=9 next edge, OVF=1. Then OVF_CLR=1 for one edge -> OVF=0. OVF_CLR=1 coincident with a wrap -> OVF stays 1.
3. SAT=1, UP=1, LD=1 with D=8, then E=1 -> Q 8,9,9,9, OVF=1. Flip UP=0 -> Q 8,7 with no idle cycle.
4. LD=1 with D=15 (MAX_VAL=9) and E=1 simultaneously -> Q=9, OVF unchanged. LD=1 with D=3 and E=0 -> Q=3.
5. Assert CLR mid-cycle while Q=6 and OVF=1 -> Q=RESET_VAL and OVF=0 before the next edge. Repeat with RESET_VAL=5 -> Q=5.
6. Cascade two instances (WIDTH=4, MAX_VAL=9, TC of the low stage drives E of the high stage), run 100 enabled edges from 00 -> high:low reads 00 after 99. High-stage increments align exactly with low-stage 9->0.

Source files
------------

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with load, wrap/saturate,
// cascadable terminal count and sticky overflow flag.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             E,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             SAT,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);
  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST = RESET_VAL[WIDTH-1:0];
  logic [WIDTH-1:0] q_q, q_d;
  logic ovf_q, ovf_d, tc;
  always_comb begin
    tc = E & ~LD & ((UP & (q_q == MAX)) | (~UP & (q_q == '0)));
    q_d = LD  ? ((D > MAX) ? MAX : D) :
          !E  ? q_q :
          tc  ? (SAT ? q_q : (UP ? '0 : MAX)) :
          UP  ? q_q + 1'b1 : q_q - 1'b1;
    ovf_d = tc | (ovf_q & ~OVF_CLR);
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q_q   <= RST;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end
  assign Q   = q_q;
  assign TC  = tc;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of decade, preset, natural-wrap and cascaded counters.
module tb_param_updown_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;

  logic rst, e, up, ld, sat, oc;
  logic [3:0] d, q0;
  logic tc0, ovf0;
  logic clr5, e5;
  logic [3:0] q5;
  logic tc5, ovf5;
  logic ldf, ef, upf;
  logic [3:0] df, qf;
  logic tcf, ovff;
  logic ec;
  logic [3:0] ql, qh;
  logic tcl, tch, ovfl, ovfh;
  logic clr0;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u0 (
    .CLK(clk), .CLR(clr0), .E(e), .UP(up), .LD(ld), .D(d), .SAT(sat), .OVF_CLR(oc),
    .Q(q0), .TC(tc0), .OVF(ovf0));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(5)) u5 (
    .CLK(clk), .CLR(clr5), .E(e5), .UP(1'b1), .LD(1'b0), .D(4'd0), .SAT(1'b0), .OVF_CLR(1'b0),
    .Q(q5), .TC(tc5), .OVF(ovf5));
  param_updown_counter #(.WIDTH(4)) uf (
    .CLK(clk), .CLR(rst), .E(ef), .UP(upf), .LD(ldf), .D(df), .SAT(1'b0), .OVF_CLR(1'b0),
    .Q(qf), .TC(tcf), .OVF(ovff));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) ulo (
    .CLK(clk), .CLR(rst), .E(ec), .UP(1'b1), .LD(1'b0), .D(4'd0), .SAT(1'b0), .OVF_CLR(1'b0),
    .Q(ql), .TC(tcl), .OVF(ovfl));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) uhi (
    .CLK(clk), .CLR(rst), .E(tcl), .UP(1'b1), .LD(1'b0), .D(4'd0), .SAT(1'b0), .OVF_CLR(1'b0),
    .Q(qh), .TC(tch), .OVF(ovfh));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; clr0 = 1; clr5 = 1; e = 0; up = 0; ld = 0; sat = 0; oc = 0; d = 0;
    e5 = 0; ldf = 0; ef = 0; upf = 0; df = 0; ec = 0;
    #12;
    chk("rst_q", q0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_tc", tc0, 0);
    chk("rst5_q", q5, 5);
    rst = 0; clr0 = 0; e = 1; up = 1;
    chk("tc_q0_up", tc0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("up_q", q0, i % 10);
      chk("up_tc", tc0, (i % 10) == 9);
      chk("up_ovf", ovf0, i == 10);
    end
    up = 0;
    #1 chk("dn_tc_at0", tc0, 1);
    step();
    chk("dn_wrap_q", q0, 9);
    chk("dn_wrap_ovf", ovf0, 1);
    e = 0; oc = 1;
    step();
    chk("ovfclr_ovf", ovf0, 0);
    chk("ovfclr_q", q0, 9);
    e = 1; up = 1;
    step();
    chk("set_vs_clr_q", q0, 0);
    chk("set_vs_clr_ovf", ovf0, 1);
    sat = 1; ld = 1; d = 8;
    step();
    chk("sat_ld_q", q0, 8);
    chk("ld_ovfclr_ovf", ovf0, 0);
    ld = 0; oc = 0;
    step();
    chk("sat_q9", q0, 9);
    chk("sat_ovf0", ovf0, 0);
    chk("sat_tc", tc0, 1);
    step();
    chk("sat_hold1", q0, 9);
    chk("sat_ovf1", ovf0, 1);
    step();
    chk("sat_hold2", q0, 9);
    up = 0;
    step();
    chk("flip_q8", q0, 8);
    step();
    chk("flip_q7", q0, 7);
    ld = 1; d = 15; up = 1;
    step();
    chk("clamp_q", q0, 9);
    chk("clamp_ovf", ovf0, 1);
    chk("tc_ld_mask", tc0, 0);
    ld = 0; e = 0; oc = 1;
    step();
    chk("clr2_ovf", ovf0, 0);
    oc = 0; ld = 1; e = 1;
    step();
    chk("ld_at_max_q", q0, 9);
    chk("ld_no_ovf", ovf0, 0);
    d = 3; e = 0;
    step();
    chk("ld3_q", q0, 3);
    d = 0;
    step();
    ld = 0; e = 1; up = 0; sat = 0;
    step();
    chk("pre_q9", q0, 9);
    repeat (3) step();
    e = 0;
    chk("pre_q6", q0, 6);
    chk("pre_ovf", ovf0, 1);
    #2 clr0 = 1;
    #1;
    chk("async_q", q0, 0);
    chk("async_ovf", ovf0, 0);
    step();
    chk("clr_hold_q", q0, 0);
    clr0 = 0; e = 1; up = 1;
    step();
    chk("post_clr_q", q0, 1);
    e = 0;
    clr5 = 0; e5 = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("r5_q", q5, (5 + i) % 10);
    end
    chk("r5_ovf", ovf5, 1);
    e5 = 0;
    #2 clr5 = 1;
    #1;
    chk("r5_async_q", q5, 5);
    chk("r5_async_ovf", ovf5, 0);
    @(negedge clk);
    clr5 = 0; e5 = 1;
    step();
    chk("r5_count_q", q5, 6);
    e5 = 0;
    ldf = 1; df = 15;
    step();
    chk("nat_ld", qf, 15);
    ldf = 0; ef = 1; upf = 1;
    #1 chk("nat_tc", tcf, 1);
    step();
    chk("nat_wrap_q", qf, 0);
    chk("nat_wrap_ovf", ovff, 1);
    upf = 0;
    step();
    chk("nat_dn_q", qf, 15);
    ef = 0;
    ec = 1;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk("casc_lo", ql, (i % 100) % 10);
      chk("casc_hi", qh, (i % 100) / 10);
    end
    chk("casc_hi_ovf", ovfh, 1);
    chk("casc_lo_ovf", ovfl, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
